alu_result_stage: RTL and testbench

//  Registered output stage placed directly downstream of the 8-to-1 ALU result mux.
//  - Captures the selected result together with its 3-bit select code.
//  - Derives zero and negative flags from the result.
//  - Presents the result to the consumer over a valid/ready handshake.
//  - A 2-entry skid buffer gives full throughput without a combinational ready path.

---
 rtl/alu_result_stage.sv | 119 +++++++++++
 tb/tb_alu_result_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 8-to-1 ALU result mux.
// It captures the result and its select code and derives zero and negative flags.
// The result is presented over a valid/ready handshake.
// A main register plus a one-word skid register keep in_ready registered.
// They also allow one word per clock.
// Optional feature macro: ALU_RES_PARITY_EN.
// When it is defined, an even-parity bit out_par is stored and presented with each word.
module alu_result_stage #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] res_in,
    input  logic [2:0]   op_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_op,
    output logic         out_zero,
    output logic         out_neg,
`ifdef ALU_RES_PARITY_EN
    output logic         out_par,
`endif
    output logic         out_valid,
    input  logic         out_ready
);

`ifdef ALU_RES_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    // Stored word layout: {[par], neg, zero, op[2:0], data[N-1:0]}
    localparam int W = N + 5 + PW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_main;
    logic [W-1:0]   r_skid;
    logic [W-1:0]   w_in_word;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           w_accept;
    logic           w_emit;

    assign w_accept = in_valid && r_in_ready;
    assign w_emit   = r_out_valid && out_ready;

    // Build the word to store, flags computed once at capture so they travel with the data
    always_comb begin
        w_in_word          = '0;
        w_in_word[N-1:0]   = res_in;
        w_in_word[N+2:N]   = op_in;
        w_in_word[N+3]     = (res_in == '0);
        w_in_word[N+4]     = res_in[N-1];
`ifdef ALU_RES_PARITY_EN
        w_in_word[N+5]     = ^res_in;
`endif
    end

    // Occupancy transition from the accept/emit handshakes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_emit)      w_next_state = ST_FULL;
                else if (!w_accept && w_emit) w_next_state = ST_EMPTY;
            end
            ST_FULL:  if (w_emit) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    // Storage, occupancy state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_FULL);
            r_out_valid <= (w_next_state != ST_EMPTY);
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) r_main <= w_in_word;
                end
                ST_ONE: begin
                    if (w_accept && w_emit) r_main <= w_in_word;
                    else if (w_accept)      r_skid <= w_in_word;
                end
                ST_FULL: begin
                    if (w_emit) r_main <= r_skid;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main[N-1:0];
    assign out_op    = r_main[N+2:N];
    assign out_zero  = r_main[N+3];
    assign out_neg   = r_main[N+4];
`ifdef ALU_RES_PARITY_EN
    assign out_par   = r_main[N+5];
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed vectors with hand-computed expectations.
// The driver pushes the expected word when the word is accepted.
// A monitor pops and compares each word when it is emitted.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] res_in;
    logic [2:0] op_in;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] out_data;
    logic [2:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic       out_valid;
    logic       out_ready;
`ifdef ALU_RES_PARITY_EN
    logic       out_par;
`endif

    always #5 clk = ~clk;

    alu_result_stage #(.N(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_in    (res_in),
        .op_in     (op_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`ifdef ALU_RES_PARITY_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [4:0] d;
        logic [2:0] op;
        logic       z;
        logic       n;
        logic       p;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Monitor: compare each emitted word against the scoreboard and check stall stability
    logic        prev_stall = 1'b0;
    logic [10:0] prev_out;
    always @(negedge clk) begin
        if (prev_stall && rst_n)
            chk("stall_stable", {21'd0, out_valid, out_data, out_op, out_zero, out_neg}, {21'd0, prev_out});
        prev_stall = rst_n && out_valid && !out_ready;
        prev_out   = {out_valid, out_data, out_op, out_zero, out_neg};
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got data=%0h op=%0d with no word outstanding", out_data, out_op);
            end else begin
                exp_t e;
                logic p_got;
                e = sb_q.pop_front();
`ifdef ALU_RES_PARITY_EN
                p_got = out_par;
`else
                p_got = e.p;
`endif
                if (out_data !== e.d || out_op !== e.op || out_zero !== e.z || out_neg !== e.n || p_got !== e.p) begin
                    n_err++;
                    $display("FAIL sb_word: got d=%0h op=%0d z=%0b n=%0b p=%0b want d=%0h op=%0d z=%0b n=%0b p=%0b",
                             out_data, out_op, out_zero, out_neg, p_got, e.d, e.op, e.z, e.n, e.p);
                end else begin
                    $display("ok   sb_word: d=%0h op=%0d z=%0b n=%0b p=%0b", out_data, out_op, out_zero, out_neg, p_got);
                end
            end
        end
    end

    // Present one word; returns the number of cycles it waited for acceptance
    task automatic send(input logic [4:0] d, input logic [2:0] op, input logic z, input logic n,
                        input logic p, output int tries);
        logic accepted;
        exp_t e;
        accepted = 1'b0;
        tries    = 0;
        res_in   = d;
        op_in    = op;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            tries++;
            if (in_ready) begin
                e.d = d; e.op = op; e.z = z; e.n = n; e.p = p;
                sb_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: word %0h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
        res_in   = 'x;
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    int tr;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        res_in    = 5'h1F;
        op_in     = 3'd5;
        out_ready = 1'b0;

        // Reset held for 3 clocks with in_valid high
        step(3);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", {27'd0, out_data}, 32'd0);
        chk("rst_flags", {27'd0, out_op, out_zero, out_neg}, 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_no_capture", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Single word: negative result
        send(5'h10, 3'd3, 1'b0, 1'b1, 1'b1, tr);
        chk("single_latency", {31'd0, out_valid}, 32'd1);
        step(1);

        // Zero flag
        send(5'h00, 3'd7, 1'b1, 1'b0, 1'b0, tr);
        chk("zero_latency", {31'd0, out_valid}, 32'd1);
        step(2);
        chk("idle_empty", {31'd0, out_valid}, 32'd0);

        // Back-pressure: two words fill main and skid
        out_ready = 1'b0;
        send(5'h01, 3'd1, 1'b0, 1'b0, 1'b1, tr);
        send(5'h02, 3'd2, 1'b0, 1'b0, 1'b1, tr);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data", {27'd0, out_data}, 32'h01);
        fork
            begin
                send(5'h03, 3'd4, 1'b0, 1'b0, 1'b0, tr);
                send(5'h04, 3'd6, 1'b0, 1'b0, 1'b1, tr);
            end
            begin
                step(3);
                chk("bp_still_full", {31'd0, in_ready}, 32'd0);
                chk("bp_still_holds", {27'd0, out_data}, 32'h01);
                out_ready = 1'b1;
            end
        join
        step(4);
        chk("bp_drained", sb_q.size(), 32'd0);

        // Throughput: 16 words on 16 consecutive clocks
        for (int i = 0; i < 16; i++) begin
            logic [4:0] v;
            v = 5'(i);
            send(v, 3'(i), (i == 0), 1'b0, ^v, tr);
            chk("tput_no_wait", tr, 32'd1);
            chk("tput_out_valid", {31'd0, out_valid}, 32'd1);
        end
        step(1);
        chk("tput_drained", sb_q.size(), 32'd0);
        step(1);

        // Mid-stream reset while FULL
        out_ready = 1'b0;
        send(5'h0A, 3'd1, 1'b0, 1'b0, 1'b0, tr);
        send(5'h15, 3'd2, 1'b0, 1'b1, 1'b1, tr);
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        sb_q.delete();
        out_ready = 1'b1;
        step(1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        step(4);
        chk("mid_after_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_after_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_RES_PARITY_EN
        send(5'b10110, 3'd2, 1'b0, 1'b1, 1'b1, tr);
        chk("par_10110", {31'd0, out_par}, 32'd1);
        send(5'b00011, 3'd3, 1'b0, 1'b0, 1'b0, tr);
        chk("par_00011", {31'd0, out_par}, 32'd0);
        step(2);
`endif

        step(2);
        chk("final_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
